mem_bus_arbiter: RTL

- Shares the single CPU memory bus between the instruction-fetch port and the data (load/store) port.
- Runs each bus access as a fixed sequence: address phase, then a configurable number of wait states, then a response.
- Drives a stall signal to the core so the pipeline holds while either port is still waiting for its access to complete.
- Sits between the CPU core and the memory clock/memory block.

---
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port (instruction fetch / data) arbiter for the single CPU memory bus.
// Each access runs IDLE -> ACCESS -> WAIT x WAIT_CYCLES -> RESP. The core is stalled until its ack arrives.
module mem_bus_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int MAX_CONSEC  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_ack,
    output logic [DW-1:0]     if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    input  logic [DW/8-1:0]   d_be,
    output logic              d_ack,
    output logic [DW-1:0]     d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_be,
    input  logic [DW-1:0]     mem_rdata,
    output logic              mem_src,
    output logic              stall,
    output logic              busy
);

    localparam int         BW     = DW / 8;
    localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);
    localparam logic [3:0] MAX_C  = 4'(MAX_CONSEC);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t          state_q;
    logic [3:0]      consec_q, consec_d;
    logic [3:0]      wcnt_q;
    logic            src_q, we_q;
    logic            mem_en_q, mem_we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [BW-1:0]   be_q;
    logic            if_ack_q, d_ack_q;
    logic [DW-1:0]   if_rdata_q, d_rdata_q;
    logic            gnt_data;
    logic            resp_d;

    always_comb begin
        gnt_data = d_req & (~if_req | (consec_q != MAX_C));
        consec_d = consec_q;
        if (gnt_data) begin
            // Only contended data grants count toward the fetch-starvation limit
            if (if_req && (consec_q < MAX_C)) consec_d = consec_q + 4'd1;
        end else if (if_req) begin
            consec_d = '0;
        end
        resp_d = ((state_q == ACCESS) && (WAIT_CYCLES == 0)) ||
                 ((state_q == WAIT) && (wcnt_q <= 4'd1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            consec_q   <= '0;
            wcnt_q     <= '0;
            src_q      <= 1'b0;
            we_q       <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (if_req || d_req) begin
                        state_q  <= ACCESS;
                        consec_q <= consec_d;
                        src_q    <= gnt_data;
                        we_q     <= gnt_data & d_we;
                        mem_en_q <= 1'b1;
                        mem_we_q <= gnt_data & d_we;
                        if (gnt_data) begin
                            addr_q  <= d_addr;
                            wdata_q <= d_wdata;
                            be_q    <= d_be;
                        end else begin
                            addr_q <= if_addr;
                            be_q   <= '1;
                        end
                    end
                end
                ACCESS: begin
                    mem_we_q <= 1'b0;
                    if (!resp_d) begin
                        wcnt_q  <= WAIT_C;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!resp_d) wcnt_q <= wcnt_q - 4'd1;
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            // Shared exit from ACCESS (no wait states) or the last WAIT cycle
            if (resp_d) begin
                state_q  <= RESP;
                mem_en_q <= 1'b0;
                wcnt_q   <= '0;
                if (src_q) d_ack_q  <= 1'b1;
                else       if_ack_q <= 1'b1;
                if (!we_q) begin
                    if (src_q) d_rdata_q  <= mem_rdata;
                    else       if_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign mem_src   = src_q;
    assign busy      = (state_q != IDLE);
    assign stall     = reset_n & ((if_req & ~if_ack_q) | (d_req & ~d_ack_q));

endmodule
